// File: rtl/alu_div_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_div_sequencer_if
//  Brief    : Request/result and ALU operand/control bundle for the divider.
//  Revision : 1.0
// ============================================================================
interface alu_div_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              start_i;
    logic [DATA_W-1:0] dividend_i;
    logic [DATA_W-1:0] divisor_i;
    logic              busy_o;
    logic              done_o;
    logic              dz_o;
    logic [DATA_W-1:0] quotient_o;
    logic [DATA_W-1:0] remainder_o;
    logic [DATA_W-1:0] alu_src1_o;
    logic [DATA_W-1:0] alu_src2_o;
    logic [3:0]        alu_ctrl_o;
    logic [DATA_W-1:0] alu_result_i;
    logic              alu_zero_i;
    logic              alu_cout_i;

    // Environment side: issues requests and hosts the combinational ALU.
    modport master (
        output start_i, dividend_i, divisor_i,
        output alu_result_i, alu_zero_i, alu_cout_i,
        input  busy_o, done_o, dz_o, quotient_o, remainder_o,
        input  alu_src1_o, alu_src2_o, alu_ctrl_o
    );

    // Divider side.
    modport slave (
        input  start_i, dividend_i, divisor_i,
        input  alu_result_i, alu_zero_i, alu_cout_i,
        output busy_o, done_o, dz_o, quotient_o, remainder_o,
        output alu_src1_o, alu_src2_o, alu_ctrl_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_div_sequencer
//  Brief    : 32-bit unsigned restoring divider driving an external ALU.
//  Revision : 1.0
// ============================================================================
module alu_div_sequencer #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] DZ_QUOT = '1
) (
    input  wire logic         clk_i,
    input  wire logic         rst_n,
    alu_div_sequencer_if.slave bus
);
    localparam logic [3:0] C_ALU_AND = 4'b0000;
    localparam logic [3:0] C_ALU_OR  = 4'b0001;
    localparam logic [3:0] C_ALU_SUB = 4'b0110;
    localparam logic [4:0] C_LAST    = 5'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ITER  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              dz_q, dz_d;

    logic [DATA_W-1:0] shift_w;
    logic [DATA_W-1:0] src1_w;
    logic [DATA_W-1:0] src2_w;
    logic [3:0]        ctrl_w;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        src1_w  = '0;
        src2_w  = '0;
        ctrl_w  = C_ALU_AND;
        shift_w = {r_q[DATA_W-2:0], q_q[DATA_W-1]};

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start_i) begin
                    state_d = S_CHECK;
                    d_d     = bus.divisor_i;
                    q_d     = bus.dividend_i;
                    r_d     = '0;
                    dz_d    = 1'b0;
                end
            end
            S_CHECK: begin
                // OR with zero lets the ALU zero flag flag a zero divisor.
                ctrl_w = C_ALU_OR;
                src1_w = d_q;
                if (bus.alu_zero_i) begin
                    state_d = S_DONE;
                    quot_d  = DZ_QUOT;
                    rem_d   = q_q;
                    dz_d    = 1'b1;
                end else begin
                    state_d = S_ITER;
                    cnt_d   = '0;
                end
            end
            S_ITER: begin
                ctrl_w = C_ALU_SUB;
                src1_w = shift_w;
                src2_w = d_q;
                // r_q[MSB] stands in for the 33rd bit of the shifted remainder.
                if (r_q[DATA_W-1] | bus.alu_cout_i) begin
                    r_d = bus.alu_result_i;
                    q_d = {q_q[DATA_W-2:0], 1'b1};
                end else begin
                    r_d = shift_w;
                    q_d = {q_q[DATA_W-2:0], 1'b0};
                end
                if (cnt_q == C_LAST) begin
                    state_d = S_DONE;
                    quot_d  = q_d;
                    rem_d   = r_d;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy_o      = (state_q == S_CHECK) || (state_q == S_ITER);
    assign bus.done_o      = (state_q == S_DONE);
    assign bus.dz_o        = dz_q;
    assign bus.quotient_o  = quot_q;
    assign bus.remainder_o = rem_q;
    assign bus.alu_src1_o  = src1_w;
    assign bus.alu_src2_o  = src2_w;
    assign bus.alu_ctrl_o  = ctrl_w;
endmodule
`default_nettype wire

// File: tb/tb_alu_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_div_sequencer
//  Brief    : Scoreboard bench for alu_div_sequencer with a behavioural ALU.
//  Revision : 1.0
// ============================================================================
module tb_alu_div_sequencer;
    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          done_cyc;
        int          n_sub;
    } exp_t;

    exp_t exp_q[$];

    alu_div_sequencer_if bus ();

    alu_div_sequencer dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural ALU: AND/OR/ADD/SUB, cout = carry out of src1 + ~src2 + 1 for SUB.
    logic [32:0] alu_sub;
    logic [31:0] alu_res;
    logic        alu_co;
    always_comb begin
        alu_sub = {1'b0, bus.alu_src1_o} + {1'b0, ~bus.alu_src2_o} + 33'd1;
        alu_res = '0;
        alu_co  = 1'b0;
        case (bus.alu_ctrl_o)
            4'b0000: alu_res = bus.alu_src1_o & bus.alu_src2_o;
            4'b0001: alu_res = bus.alu_src1_o | bus.alu_src2_o;
            4'b0010: {alu_co, alu_res} = {1'b0, bus.alu_src1_o} + {1'b0, bus.alu_src2_o};
            4'b0110: begin
                alu_res = alu_sub[31:0];
                alu_co  = alu_sub[32];
            end
            default: alu_res = '0;
        endcase
    end
    assign bus.alu_result_i = alu_res;
    assign bus.alu_cout_i   = alu_co;
    assign bus.alu_zero_i   = (alu_res == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    initial begin : monitor
        int   n_sub;
        int   n_or;
        logic prev_done;
        exp_t e;
        n_sub = 0;
        n_or = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_n) begin
                n_sub = 0;
                n_or = 0;
                prev_done = 1'b0;
            end else begin
                if (bus.alu_ctrl_o == 4'b0110) n_sub++;
                if (bus.alu_ctrl_o == 4'b0001) n_or++;
                if (bus.done_o) begin
                    chk("done_width", {31'd0, prev_done}, 32'd0);
                    chk("busy_at_done", {31'd0, bus.busy_o}, 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("quotient", bus.quotient_o, e.q);
                        chk("remainder", bus.remainder_o, e.r);
                        chk("dz", {31'd0, bus.dz_o}, {31'd0, e.dz});
                        chk("latency_cycle", cyc, e.done_cyc);
                        chk("sub_cycles", n_sub, e.n_sub);
                        chk("or_cycles", n_or, 32'd1);
                    end
                    n_sub = 0;
                    n_or = 0;
                end
                prev_done = bus.done_o;
            end
        end
    end

    // Called on a negedge; start is sampled at the following posedge.
    task automatic push_exp(input logic [31:0] q, input logic [31:0] r, input logic dz);
        exp_t e;
        e.q        = q;
        e.r        = r;
        e.dz       = dz;
        e.done_cyc = cyc + (dz ? 2 : 34);
        e.n_sub    = dz ? 0 : 32;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic dz);
        @(negedge clk_i);
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.start_i    = 1'b1;
        push_exp(q, r, dz);
        @(negedge clk_i);
        bus.start_i    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        @(negedge clk_i);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done_o}, 32'd0);
        chk({tag, "_dz"}, {31'd0, bus.dz_o}, 32'd0);
        chk({tag, "_quot"}, bus.quotient_o, 32'd0);
        chk({tag, "_rem"}, bus.remainder_o, 32'd0);
        chk({tag, "_src1"}, bus.alu_src1_o, 32'd0);
        chk({tag, "_src2"}, bus.alu_src2_o, 32'd0);
        chk({tag, "_ctrl"}, {28'd0, bus.alu_ctrl_o}, 32'd0);
    endtask

    initial begin : driver
        int n;
        int seen;
        bus.start_i    = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        repeat (3) @(negedge clk_i);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);

        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        drain();
        issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        drain();
        issue(32'd3, 32'd10, 32'd0, 32'd3, 1'b0);
        drain();
        issue(32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0);
        drain();
        issue(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        drain();
        repeat (3) @(negedge clk_i);
        chk("dz_held", {31'd0, bus.dz_o}, 32'd1);
        chk("quot_held", bus.quotient_o, 32'hFFFF_FFFF);
        chk("rem_held", bus.remainder_o, 32'd5);

        // Start while busy is ignored; start during DONE is accepted back-to-back.
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (8) @(negedge clk_i);
        bus.dividend_i = 32'd9;
        bus.divisor_i  = 32'd2;
        bus.start_i    = 1'b1;
        @(negedge clk_i);
        bus.start_i    = 1'b0;
        bus.dividend_i = 32'hDEAD_BEEF;
        bus.divisor_i  = 32'h1234_5678;
        n = 0;
        while (!bus.done_o && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        chk("b2b_done_seen", {31'd0, bus.done_o}, 32'd1);
        bus.dividend_i = 32'd9;
        bus.divisor_i  = 32'd2;
        bus.start_i    = 1'b1;
        push_exp(32'd4, 32'd1, 1'b0);
        @(negedge clk_i);
        bus.start_i    = 1'b0;
        chk("b2b_busy", {31'd0, bus.busy_o}, 32'd1);
        drain();

        // Reset in the middle of an iteration.
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (10) @(negedge clk_i);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk_all_zero("midrst");
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (bus.done_o || bus.busy_o) seen++;
        end
        chk("no_activity_after_reset", seen, 32'd0);
        chk_all_zero("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/alu_div_sequencer.md
Name: alu_div_sequencer

Overview:
- Multi-cycle unsigned 32-bit divider that acts as the initiator on the ALU operand/control interface.
- Drives src1, src2 and ALU_control of an external combinational ALU instance each cycle, and consumes its result, zero and cout.
- Produces quotient and remainder by restoring division.
- Sits beside the ALU in the datapath and shares it with no other master while busy.

Parameters:
- DATA_W, 32: operand width. Must equal the ALU width; only 32 is supported.
- DZ_QUOT, 32'hFFFFFFFF: quotient returned on divide-by-zero.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  request; sampled only when idle or in DONE.
- dividend_i  in  32  dividend; captured on start acceptance.
- divisor_i  in  32  divisor; captured on start acceptance.
- busy_o  out  1  high from acceptance until done.
- done_o  out  1  single-cycle completion pulse.
- dz_o  out  1  divide-by-zero flag; held with the results.
- quotient_o  out  32  result, held until next acceptance.
- remainder_o  out  32  result, held until next acceptance.
- alu_src1_o  out  32  to ALU src1.
- alu_src2_o  out  32  to ALU src2.
- alu_ctrl_o  out  4  to ALU ALU_control.
- alu_result_i  in  32  from ALU result.
- alu_zero_i  in  1  from ALU zero.
- alu_cout_i  in  1  from ALU cout.

Behaviour:
- Reset (async, any state): state=IDLE; busy_o, done_o and dz_o = 0; quotient_o, remainder_o and all internal registers = 0.
- ALU drive in IDLE and DONE: alu_ctrl_o=4'b0000 (AND), alu_src1_o=0, alu_src2_o=0.
- ALU encodings used: 0001 OR, 0110 SUB.
  - The ALU is combinational, so results are valid in the same cycle and are consumed at the next edge.
  - For SUB, cout=1 means src1 >= src2 unsigned.
- IDLE:
  - start_i=1 → CHECK.
  - Latch D=divisor_i, Q=dividend_i, R=0.
  - busy_o=1 and dz_o=0.
- CHECK:
  - Drive OR with src1=D, src2=0.
  - alu_zero_i=1 → DONE with quotient_o=DZ_QUOT, remainder_o=dividend, dz_o=1.
  - Otherwise → ITER with cnt=0.
- ITER: one iteration per cycle; cnt is 5 bits.
  - Form S={R[30:0],Q[31]} and msb=R[31].
  - Drive SUB with src1=S, src2=D.
  - If msb|alu_cout_i: R←alu_result_i and Q←{Q[30:0],1}.
  - Else: R←S and Q←{Q[30:0],0}.
  - msb covers the 33-bit partial remainder when D ≥ 2^31; the ALU result is correct mod 2^32.
  - cnt=31 → DONE, loading quotient_o=final Q and remainder_o=final R. Otherwise cnt+1.
- DONE:
  - done_o=1 for exactly this cycle; busy_o=0.
  - start_i=1 → CHECK with new operands latched (back-to-back). Otherwise → IDLE.
- Latency, with start sampled at edge k:
  - Normal: done_o high in the cycle after edge k+33 (33 cycles).
  - Divide-by-zero: done_o high after edge k+1.
- start_i while busy (CHECK/ITER) is ignored; operand inputs may change freely while busy.
- overflow is not an input. Only cout and zero are observed.
- done_o is never asserted without a preceding acceptance.
- Results and dz_o stay stable from done until the next acceptance.

Test Plan:
- 100 / 7 → quotient_o=14, remainder_o=2, dz_o=0; done_o exactly 33 cycles after the start edge, one cycle wide. alu_ctrl_o=0110 for all 32 ITER cycles.
- 32'hFFFFFFFF / 1 → quotient 32'hFFFFFFFF, remainder 0.
- 3 / 10 → quotient 0, remainder 3.
- 32'hFFFFFFFF / 32'h80000001 → quotient 1, remainder 32'h7FFFFFFE (exercises the msb path).
- 5 / 0 → dz_o=1, quotient 32'hFFFFFFFF, remainder 5; done_o 1 cycle after the start edge, and alu_ctrl_o=0001 during CHECK.
- Start 100/7, pulse start_i with 9/2 mid-ITER (ignored → 14/2). Then assert start with 9/2 during DONE → accepted back-to-back, giving 4/1. Separately, drop rst_n mid-ITER → all outputs 0 immediately, state IDLE, no done_o.
